// File: rtl/pwr_seq.sv
// pwr_seq: ordered power-up/down sequencer for OCXO, PLL, GPS, DAC and display.
// Order is OCXO settle -> PLL lock -> GPS settle -> RUN, reversed on shutdown.
// Ports: clk, rst_n (async, active low), run (level request), locked (async PLL lock);
//   outputs ocxo_ena, pll_rst_n, gps_ena, dac_ena, disp_ena, ready, busy, fault,
//   state[2:0]; retry_cnt[3:0] only when PWR_SEQ_RETRY_EN is defined.
// PWR_SEQ_RETRY_EN: a PLL lock timeout pulses the PLL reset and retries instead of faulting.
module pwr_seq #(
    parameter int unsigned OCXO_SETTLE  = 5000,
    parameter int unsigned LOCK_TIMEOUT = 65535,
    parameter int unsigned GPS_SETTLE   = 5000,
    parameter int unsigned CTR_W        = 17
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       locked,
    output logic       ocxo_ena,
    output logic       pll_rst_n,
    output logic       gps_ena,
    output logic       dac_ena,
    output logic       disp_ena,
    output logic       ready,
    output logic       busy,
    output logic       fault,
`ifdef PWR_SEQ_RETRY_EN
    output logic [3:0] retry_cnt,
`endif
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_OFF      = 3'd0,
        S_OCXO     = 3'd1,
        S_PLL      = 3'd2,
        S_GPS      = 3'd3,
        S_RUN      = 3'd4,
        S_FAULT    = 3'd5,
        S_SHUTDOWN = 3'd6,
        S_RETRY    = 3'd7
    } state_t;

    localparam logic [CTR_W-1:0] OCXO_LD = CTR_W'(OCXO_SETTLE - 1);
    localparam logic [CTR_W-1:0] LOCK_LD = CTR_W'(LOCK_TIMEOUT - 1);
    localparam logic [CTR_W-1:0] GPS_LD  = CTR_W'(GPS_SETTLE - 1);
    localparam logic [CTR_W-1:0] PULSE_LD = CTR_W'(15);
    localparam logic [CTR_W-1:0] ONE     = CTR_W'(1);

    state_t           st;
    logic [CTR_W-1:0] ctr;
    logic             ctr_zero;
    logic [1:0]       sync_q;
    logic             locked_s;

    assign ctr_zero = (ctr == '0);
    assign locked_s = sync_q[1];
    assign state    = st;

    // locked comes from the PLL's own clock domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], locked};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= S_OFF;
            ctr       <= '0;
            ocxo_ena  <= 1'b0;
            pll_rst_n <= 1'b0;
            gps_ena   <= 1'b0;
            dac_ena   <= 1'b0;
            disp_ena  <= 1'b0;
            ready     <= 1'b0;
            busy      <= 1'b0;
            fault     <= 1'b0;
`ifdef PWR_SEQ_RETRY_EN
            retry_cnt <= 4'd0;
`endif
        end else if (!run && st != S_OFF && st != S_SHUTDOWN) begin
            // power-down request overrides every other transition
            st       <= S_SHUTDOWN;
            ctr      <= PULSE_LD;
            gps_ena  <= 1'b0;
            dac_ena  <= 1'b0;
            disp_ena <= 1'b0;
            ready    <= 1'b0;
            busy     <= 1'b1;
            fault    <= 1'b0;
        end else begin
            unique case (st)
                S_OFF: begin
                    if (run) begin
                        st       <= S_OCXO;
                        ocxo_ena <= 1'b1;
                        ctr      <= OCXO_LD;
                        busy     <= 1'b1;
`ifdef PWR_SEQ_RETRY_EN
                        retry_cnt <= 4'd0;
`endif
                    end
                end
                S_OCXO: begin
                    if (ctr_zero) begin
                        st        <= S_PLL;
                        pll_rst_n <= 1'b1;
                        ctr       <= LOCK_LD;
                    end else begin
                        ctr <= ctr - ONE;
                    end
                end
                S_PLL: begin
                    // lock beats a simultaneous timeout
                    if (locked_s) begin
                        st      <= S_GPS;
                        gps_ena <= 1'b1;
                        ctr     <= GPS_LD;
                    end else if (ctr_zero) begin
`ifdef PWR_SEQ_RETRY_EN
                        st        <= S_RETRY;
                        pll_rst_n <= 1'b0;
                        ctr       <= PULSE_LD;
                        if (retry_cnt != 4'hf) begin
                            retry_cnt <= retry_cnt + 4'd1;
                        end
`else
                        st        <= S_FAULT;
                        pll_rst_n <= 1'b0;
                        gps_ena   <= 1'b0;
                        dac_ena   <= 1'b0;
                        disp_ena  <= 1'b0;
                        busy      <= 1'b0;
                        fault     <= 1'b1;
`endif
                    end else begin
                        ctr <= ctr - ONE;
                    end
                end
                S_GPS: begin
                    // lock loss here is left for RUN to catch
                    if (ctr_zero) begin
                        st       <= S_RUN;
                        dac_ena  <= 1'b1;
                        disp_ena <= 1'b1;
                        busy     <= 1'b0;
                        ready    <= 1'b1;
                    end else begin
                        ctr <= ctr - ONE;
                    end
                end
                S_RUN: begin
                    if (!locked_s) begin
                        st        <= S_FAULT;
                        pll_rst_n <= 1'b0;
                        gps_ena   <= 1'b0;
                        dac_ena   <= 1'b0;
                        disp_ena  <= 1'b0;
                        ready     <= 1'b0;
                        fault     <= 1'b1;
                    end
                end
                S_FAULT: begin
                    // sticky; the oven stays powered until run drops
                end
                S_SHUTDOWN: begin
                    if (ctr_zero) begin
                        st        <= S_OFF;
                        pll_rst_n <= 1'b0;
                        ocxo_ena  <= 1'b0;
                        busy      <= 1'b0;
                    end else begin
                        ctr <= ctr - ONE;
                    end
                end
`ifdef PWR_SEQ_RETRY_EN
                S_RETRY: begin
                    if (ctr_zero) begin
                        st        <= S_PLL;
                        pll_rst_n <= 1'b1;
                        ctr       <= LOCK_LD;
                    end else begin
                        ctr <= ctr - ONE;
                    end
                end
`endif
                default: begin
                    st        <= S_OFF;
                    ctr       <= '0;
                    ocxo_ena  <= 1'b0;
                    pll_rst_n <= 1'b0;
                    gps_ena   <= 1'b0;
                    dac_ena   <= 1'b0;
                    disp_ena  <= 1'b0;
                    ready     <= 1'b0;
                    busy      <= 1'b0;
                    fault     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwr_seq.sv
// tb_pwr_seq: directed sequence with a scoreboard of expected output bundles.
// Bundle order: ocxo, pll_rst_n, gps, dac, disp, ready, busy, fault, state.
module tb_pwr_seq;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic       locked;
    logic       ocxo_ena;
    logic       pll_rst_n;
    logic       gps_ena;
    logic       dac_ena;
    logic       disp_ena;
    logic       ready;
    logic       busy;
    logic       fault;
    logic [2:0] state;
`ifdef PWR_SEQ_RETRY_EN
    logic [3:0] retry_cnt;
`endif

    int checks = 0;
    int errors = 0;

    localparam logic [10:0] V_OFF   = {8'b0000_0000, 3'd0};
    localparam logic [10:0] V_OCXO  = {8'b1000_0010, 3'd1};
    localparam logic [10:0] V_PLL   = {8'b1100_0010, 3'd2};
    localparam logic [10:0] V_GPS   = {8'b1110_0010, 3'd3};
    localparam logic [10:0] V_RUN   = {8'b1111_1100, 3'd4};
    localparam logic [10:0] V_FAULT = {8'b1000_0001, 3'd5};
    localparam logic [10:0] V_SD0   = {8'b1000_0010, 3'd6};
    localparam logic [10:0] V_SD1   = {8'b1100_0010, 3'd6};
    localparam logic [10:0] V_RETRY = {8'b1000_0010, 3'd7};

    typedef struct {
        string       tag;
        logic [10:0] v;
    } exp_t;

    exp_t exp_q[$];

    logic [10:0] obs;
    assign obs = {ocxo_ena, pll_rst_n, gps_ena, dac_ena, disp_ena,
                  ready, busy, fault, state};

    pwr_seq #(
        .OCXO_SETTLE (8),
        .LOCK_TIMEOUT(20),
        .GPS_SETTLE  (4),
        .CTR_W       (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .locked   (locked),
        .ocxo_ena (ocxo_ena),
        .pll_rst_n(pll_rst_n),
        .gps_ena  (gps_ena),
        .dac_ena  (dac_ena),
        .disp_ena (disp_ena),
        .ready    (ready),
        .busy     (busy),
        .fault    (fault),
`ifdef PWR_SEQ_RETRY_EN
        .retry_cnt(retry_cnt),
`endif
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            @(negedge clk);
        end
    endtask

    // queue the expectation, advance n edges, then score the DUT
    task automatic at(input string tag, input int n, input logic [10:0] v);
        exp_t e;
        exp_q.push_back('{tag, v});
        step(n);
        e = exp_q.pop_front();
        checks++;
        assert (obs === e.v) else begin
            errors++;
            $error("FAIL %s got %b exp %b", e.tag, obs, e.v);
        end
    endtask

`ifdef PWR_SEQ_RETRY_EN
    task automatic chk_cnt(input string tag, input logic [3:0] v);
        checks++;
        assert (retry_cnt === v) else begin
            errors++;
            $error("FAIL %s got %0d exp %0d", tag, retry_cnt, v);
        end
    endtask
`endif

    initial begin
        rst_n  = 1'b0;
        run    = 1'b0;
        locked = 1'b1;
        repeat (3) @(negedge clk);
        at("reset", 0, V_OFF);
        rst_n = 1'b1;
        step(3);

        // normal power-up, lock stable
        run = 1'b1;
        at("t1_ocxo", 1, V_OCXO);
        at("t1_ocxo_end", 7, V_OCXO);
        at("t1_pll", 1, V_PLL);
        at("t1_gps", 1, V_GPS);
        at("t1_gps_end", 3, V_GPS);
        at("t1_run", 1, V_RUN);
        at("t1_run_hold", 5, V_RUN);

        // lock loss in RUN, fault is sticky, then shutdown
        locked = 1'b0;
        at("t3_k", 1, V_RUN);
        at("t3_k1", 1, V_RUN);
        at("t3_fault", 1, V_FAULT);
        locked = 1'b1;
        at("t3_fault_hold", 4, V_FAULT);
        run = 1'b0;
        at("t3_sd", 1, V_SD0);
        at("t3_sd_end", 15, V_SD0);
        at("t3_off", 1, V_OFF);

        // power-down in OCXO_WAIT, run pulse inside SHUTDOWN ignored
        run = 1'b1;
        at("t4_ocxo", 1, V_OCXO);
        at("t4_ocxo_c3", 2, V_OCXO);
        run = 1'b0;
        at("t4_sd", 1, V_SD0);
        at("t4_sd5", 5, V_SD0);
        run = 1'b1;
        at("t4_sd_pulse", 1, V_SD0);
        run = 1'b0;
        at("t4_sd_end", 9, V_SD0);
        at("t4_off", 1, V_OFF);
        at("t4_off_hold", 3, V_OFF);

        // lock timeout
        locked = 1'b0;
        step(3);
        run = 1'b1;
        at("t2_ocxo", 1, V_OCXO);
        at("t2_pll", 8, V_PLL);
        at("t2_pll_end", 19, V_PLL);
`ifdef PWR_SEQ_RETRY_EN
        at("t6_retry1", 1, V_RETRY);
        chk_cnt("t6_cnt1", 4'd1);
        at("t6_retry1_end", 15, V_RETRY);
        at("t6_pll2", 1, V_PLL);
        at("t6_pll2_end", 19, V_PLL);
        at("t6_retry2", 1, V_RETRY);
        chk_cnt("t6_cnt2", 4'd2);
        at("t6_pll3", 16, V_PLL);
        at("t6_retry3", 20, V_RETRY);
        chk_cnt("t6_cnt3", 4'd3);
        at("t6_r3_mid", 5, V_RETRY);
        locked = 1'b1;
        at("t6_r3_end", 10, V_RETRY);
        at("t6_pll4", 1, V_PLL);
        at("t6_gps", 1, V_GPS);
        at("t6_run", 4, V_RUN);
        chk_cnt("t6_cnt_run", 4'd3);
        run = 1'b0;
        at("t6_sd", 1, V_SD1);
        at("t6_off", 16, V_OFF);
`else
        at("t2_fault", 1, V_FAULT);
        at("t2_fault_hold", 10, V_FAULT);
        run = 1'b0;
        at("t2_sd", 1, V_SD0);
        at("t2_sd_end", 15, V_SD0);
        at("t2_off", 1, V_OFF);
        locked = 1'b1;
`endif

        // asynchronous reset in RUN, then full restart
        step(3);
        run = 1'b1;
        at("t5_ocxo", 1, V_OCXO);
`ifdef PWR_SEQ_RETRY_EN
        chk_cnt("t5_cnt_clr", 4'd0);
`endif
        at("t5_run", 13, V_RUN);
        #2 rst_n = 1'b0;
        #1 at("t5_async", 0, V_OFF);
        @(negedge clk);
        rst_n = 1'b1;
        at("t5_ocxo2", 1, V_OCXO);
        at("t5_ocxo2_end", 7, V_OCXO);
        at("t5_pll2", 1, V_PLL);
        at("t5_gps2", 1, V_GPS);
        at("t5_run2", 4, V_RUN);

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL sb_drain got %0d exp 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
